// File: rtl/zxuno_kbd_pkg.sv
// Shared constants and types for the ZX-Uno keyboard scan path.
package zxuno_kbd_pkg;
    localparam int KEYNUM_W     = 7;
    localparam int DEF_NUM_KEYS = 80;
    localparam int DEF_SCAN_DIV = 28;
    localparam int DEF_DEBOUNCE = 3;

    typedef logic [1:0] key_cnt_t;
endpackage

// File: rtl/kbd_sync2.sv
// Two-flop synchronizer, resets to all-ones so an idle (released) keyboard is seen at reset.
module kbd_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so meta->q forms two real flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/m2m_key_scanner.sv
// Debounces an active-low key bitmap and serialises it as a key_num / key_status_n scan stream.
module m2m_key_scanner
    import zxuno_kbd_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int SCAN_DIV = DEF_SCAN_DIV,
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic                clk28mhz,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keys_n_in,
    input  logic                enable,
    output logic [KEYNUM_W-1:0] key_num,
    output logic                key_status_n,
    output logic                scan_wrap
);
    localparam int IDX_W = $clog2(NUM_KEYS);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(SCAN_DIV - 1);
    localparam key_cnt_t         CNT_DONE = key_cnt_t'(DEBOUNCE - 1);

    logic [NUM_KEYS-1:0] sync_q;
    logic [NUM_KEYS-1:0] deb;
    key_cnt_t            cnt [NUM_KEYS];
    logic [DIV_W-1:0]    div;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    j;
    logic                tick;
    logic                deb_nxt;
    key_cnt_t            cnt_nxt;

    kbd_sync2 #(.WIDTH(NUM_KEYS)) u_sync (
        .clk   (clk28mhz),
        .reset (reset),
        .d     (keys_n_in),
        .q     (sync_q)
    );

    assign tick = enable && (div == LAST_DIV);
    assign j    = (idx == LAST_IDX) ? '0 : idx + 1'b1;

    // Debounce decision for the key about to be presented.
    always_comb begin
        // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
        deb_nxt = deb[j];
        cnt_nxt = '0;
        if (sync_q[j] != deb[j]) begin
            if (cnt[j] == CNT_DONE) begin
                deb_nxt = sync_q[j];
            end else begin
                cnt_nxt = cnt[j] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk28mhz) begin
        if (reset) begin
            div          <= '0;
            idx          <= '0;
            deb          <= '1;
            // NOTE: the counter array is reset too, otherwise a half-counted press could survive reset.
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt[i] <= '0;
            end
            key_num      <= '0;
            key_status_n <= 1'b1;
            scan_wrap    <= 1'b0;
        end else begin
            scan_wrap <= 1'b0;
            if (enable) begin
                div <= tick ? '0 : div + 1'b1;
            end
            if (tick) begin
                idx          <= j;
                deb[j]       <= deb_nxt;
                cnt[j]       <= cnt_nxt;
                key_num      <= KEYNUM_W'(j);
                key_status_n <= deb_nxt;
                scan_wrap    <= (idx == LAST_IDX);
            end
        end
    end
endmodule

// File: tb/tb_m2m_key_scanner.sv
// Self-checking bench: default-size scanner plus a tiny 4-key instance, both against a slot-level model.
module tb_m2m_key_scanner;
    import zxuno_kbd_pkg::*;

    localparam int BNK = DEF_NUM_KEYS;
    localparam int BSD = DEF_SCAN_DIV;
    localparam int BDB = DEF_DEBOUNCE;
    localparam int SNK = 4;
    localparam int SSD = 2;
    localparam int SDB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset = 1'b1;
    logic           enable = 1'b1;
    logic [BNK-1:0] keys_big = '1;
    logic [SNK-1:0] keys_small = '1;
    logic [KEYNUM_W-1:0] kn_b, kn_s;
    logic           st_b, st_s, wr_b, wr_s;

    m2m_key_scanner #(.NUM_KEYS(BNK), .SCAN_DIV(BSD), .DEBOUNCE(BDB)) u_big (
        .clk28mhz(clk), .reset(reset), .keys_n_in(keys_big), .enable(enable),
        .key_num(kn_b), .key_status_n(st_b), .scan_wrap(wr_b)
    );

    m2m_key_scanner #(.NUM_KEYS(SNK), .SCAN_DIV(SSD), .DEBOUNCE(SDB)) u_small (
        .clk28mhz(clk), .reset(reset), .keys_n_in(keys_small), .enable(enable),
        .key_num(kn_s), .key_status_n(st_s), .scan_wrap(wr_s)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit wrap_chk = 0;
    int last_swrap = -1;

    // Reference model state, index 0 = big instance, 1 = small instance.
    int           m_ecnt [2];
    logic [127:0] m_deb  [2];
    logic [127:0] m_d1   [2];
    logic [127:0] m_d2   [2];
    int           m_run  [2][128];
    int           m_key  [2];
    logic         m_st   [2];
    logic         m_wrap [2];

    typedef struct {
        int   key;
        logic raw;
        logic exp_st;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int p_nk(input int m); return (m == 0) ? BNK : SNK; endfunction
    function automatic int p_sd(input int m); return (m == 0) ? BSD : SSD; endfunction
    function automatic int p_db(input int m); return (m == 0) ? BDB : SDB; endfunction

    // Slot schedule is pure arithmetic on the count of enabled cycles; a key is
    // accepted after p_db consecutive differing samples taken at its own slots.
    task automatic model_edge(input int m, input logic [127:0] kin, input logic r, input logic e);
        logic [127:0] s_vec;
        int k;
        if (r) begin
            m_ecnt[m] = 0;
            m_deb[m]  = '1;
            m_d1[m]   = '1;
            m_d2[m]   = '1;
            for (int i = 0; i < 128; i++) m_run[m][i] = 0;
            m_key[m]  = 0;
            m_st[m]   = 1'b1;
            m_wrap[m] = 1'b0;
        end else begin
            s_vec     = m_d2[m];
            m_d2[m]   = m_d1[m];
            m_d1[m]   = kin;
            m_wrap[m] = 1'b0;
            if (e) begin
                if (m_ecnt[m] % p_sd(m) == p_sd(m) - 1) begin
                    k = ((m_ecnt[m] + 1) / p_sd(m)) % p_nk(m);
                    if (s_vec[k] == m_deb[m][k]) begin
                        m_run[m][k] = 0;
                    end else begin
                        m_run[m][k]++;
                        if (m_run[m][k] == p_db(m)) begin
                            m_deb[m][k] = s_vec[k];
                            m_run[m][k] = 0;
                        end
                    end
                    m_key[m]  = k;
                    m_st[m]   = m_deb[m][k];
                    m_wrap[m] = (k == 0);
                end
                m_ecnt[m]++;
            end
        end
    endtask

    task automatic step();
        logic [127:0] kb, ks;
        logic r, e;
        kb = '1; kb[BNK-1:0] = keys_big;
        ks = '1; ks[SNK-1:0] = keys_small;
        r = reset;
        e = enable;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(0, kb, r, e);
        model_edge(1, ks, r, e);
        check("big_key_num", 32'(kn_b), m_key[0]);
        check("big_status", 32'(st_b), 32'(m_st[0]));
        check("big_wrap", 32'(wr_b), 32'(m_wrap[0]));
        check("small_key_num", 32'(kn_s), m_key[1]);
        check("small_status", 32'(st_s), 32'(m_st[1]));
        check("small_wrap", 32'(wr_s), 32'(m_wrap[1]));
        if (wrap_chk && wr_s) begin
            if (last_swrap >= 0) check("small_wrap_period", cyc - last_swrap, SNK * SSD);
            last_swrap = cyc;
        end
    endtask

    // Step until instance m newly presents key, bounded by budget cycles.
    task automatic wait_present(input int m, input int key, input int budget);
        logic [KEYNUM_W-1:0] prev, cur;
        bit found;
        found = 0;
        prev  = (m == 0) ? kn_b : kn_s;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            cur = (m == 0) ? kn_b : kn_s;
            if (cur == KEYNUM_W'(key) && prev != KEYNUM_W'(key)) found = 1;
            prev = cur;
        end
        check($sformatf("wait_key%0d_inst%0d", key, m), 32'(found), 1);
    endtask

    task automatic wait_big_wrap();
        bit found;
        found = 0;
        for (int i = 0; i < BNK * BSD + 100 && !found; i++) begin
            step();
            if (wr_b) found = 1;
        end
        check("wait_big_wrap", 32'(found), 1);
    endtask

    task automatic wait_any_tick();
        logic [KEYNUM_W-1:0] prev;
        bit found;
        found = 0;
        prev  = kn_b;
        for (int i = 0; i < BSD + 4 && !found; i++) begin
            step();
            if (kn_b != prev) found = 1;
        end
        check("wait_any_tick", 32'(found), 1);
    endtask

    vec_t vecs [15];
    int   t, t0;

    initial begin
        // key 5: press after 3 visits, release after 3 visits
        vecs[0]  = '{5, 1'b0, 1'b1};
        vecs[1]  = '{5, 1'b0, 1'b1};
        vecs[2]  = '{5, 1'b0, 1'b0};
        vecs[3]  = '{5, 1'b1, 1'b0};
        vecs[4]  = '{5, 1'b1, 1'b0};
        vecs[5]  = '{5, 1'b1, 1'b1};
        // key 12: bounce clears the count
        vecs[6]  = '{12, 1'b0, 1'b1};
        vecs[7]  = '{12, 1'b0, 1'b1};
        vecs[8]  = '{12, 1'b1, 1'b1};
        vecs[9]  = '{12, 1'b0, 1'b1};
        vecs[10] = '{12, 1'b0, 1'b1};
        vecs[11] = '{12, 1'b0, 1'b0};
        vecs[12] = '{12, 1'b1, 1'b0};
        vecs[13] = '{12, 1'b1, 1'b0};
        vecs[14] = '{12, 1'b1, 1'b1};

        reset = 1'b1;
        step();
        step();
        check("rst_big_key_num", 32'(kn_b), 0);
        check("rst_big_status", 32'(st_b), 1);
        check("rst_big_wrap", 32'(wr_b), 0);
        check("rst_small_key_num", 32'(kn_s), 0);
        check("rst_small_status", 32'(st_s), 1);
        reset = 1'b0;
        wrap_chk = 1;

        t = 0;
        for (int i = 0; i < BSD + 10 && t == 0; i++) begin
            step();
            if (kn_b == KEYNUM_W'(1)) t = i + 1;
        end
        check("first_tick_latency", t, BSD);

        // Small instance: DEBOUNCE=1 accepts on the first visit.
        wait_present(1, 3, 20);
        keys_small[2] = 1'b0;
        wait_present(1, 2, 20);
        check("small_press_first_visit", 32'(st_s), 0);
        keys_small[2] = 1'b1;
        wait_present(1, 2, 20);
        check("small_release_first_visit", 32'(st_s), 1);

        wait_big_wrap();
        check("wrap_at_key0", 32'(kn_b), 0);
        t0 = cyc;
        wait_big_wrap();
        check("big_wrap_period", cyc - t0, BNK * BSD);
        wrap_chk = 0;

        wait_any_tick();
        for (int i = 0; i < 15; i++) begin
            keys_big[vecs[i].key] = vecs[i].raw;
            wait_present(0, vecs[i].key, BNK * BSD + 40);
            check($sformatf("vec%0d_key%0d_status", i, vecs[i].key), 32'(st_b), 32'(vecs[i].exp_st));
        end

        // Freeze mid-slot at key 40.
        wait_present(0, 40, BNK * BSD + 40);
        repeat (10) step();
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            check("hold_key_num", 32'(kn_b), 40);
        end
        enable = 1'b1;
        t = 0;
        for (int i = 0; i < BSD + 10 && t == 0; i++) begin
            step();
            if (kn_b == KEYNUM_W'(41)) t = i + 1;
        end
        check("resume_cycles", t, BSD - 10);

        // Reset while key 7 is debounced pressed.
        keys_big[7] = 1'b0;
        repeat (3) wait_present(0, 7, BNK * BSD + 40);
        check("k7_pressed", 32'(st_b), 0);
        repeat (500) step();
        reset = 1'b1;
        step();
        check("midscan_rst_key_num", 32'(kn_b), 0);
        check("midscan_rst_status", 32'(st_b), 1);
        reset = 1'b0;
        for (int v = 0; v < 3; v++) begin
            wait_present(0, 7, BNK * BSD + 40);
            check($sformatf("k7_redebounce_visit%0d", v + 1), 32'(st_b), (v < 2) ? 1 : 0);
        end
        keys_big[7] = 1'b1;

        // Random traffic: slow big-key toggles, fast small-key noise, enable gaps, one reset.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                t = $urandom_range(0, BNK - 1);
                keys_big[t] = ~keys_big[t];
            end
            keys_small = SNK'($urandom);
            enable = ($urandom_range(0, 19) != 0);
            reset  = (i == 3000);
            step();
        end
        reset  = 1'b0;
        enable = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
